// File: rtl/sysid_boot_checker.sv
// Post-reset sequencer: reads sysid word 0 (ID) and word 1 (timestamp) over Avalon-MM,
// compares both with build-time values and reports one pass/fail status with timeout/retry.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1498439491,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    output logic [3:0]  retries_used
);

    // state | meaning
    // IDLE  | after reset, waiting for auto start or start
    // RD_ID | reading word 0
    // RD_TS | reading word 1
    // GAP   | one idle bus cycle before retrying from word 0
    // CHECK | compare captured words
    // DONE  | result valid
    // FAIL  | retries exhausted on a stalled read
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_ID = 3'd1;
    localparam logic [2:0] S_RD_TS = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_FAIL  = 3'd6;

    localparam logic [15:0] TO_LIM    = 16'(TIMEOUT_CYCLES);
    localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRIES);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic        r_avm_read;
    logic        r_avm_address;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout_err;
    logic [31:0] r_captured_id;
    logic [31:0] r_captured_ts;
    logic [3:0]  r_retries;

    logic [2:0]  w_next;
    logic [15:0] w_cnt_inc;
    logic        w_accept;
    logic        w_timeout;
    logic        w_reading;
    logic        w_launch;
    logic [2:0]  w_stall_next;

    assign w_reading    = (r_state == S_RD_ID) || (r_state == S_RD_TS);
    assign w_accept     = r_avm_read && !avm_waitrequest;
    assign w_cnt_inc    = r_cnt + 16'd1;
    assign w_timeout    = avm_waitrequest && (w_cnt_inc == TO_LIM);
    assign w_stall_next = (r_retries < RETRY_LIM) ? S_GAP : S_FAIL;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (AUTO_START || start) w_next = S_RD_ID;
            S_RD_ID: begin
                if (w_accept)       w_next = S_RD_TS;
                else if (w_timeout) w_next = w_stall_next;
            end
            S_RD_TS: begin
                if (w_accept)       w_next = S_CHECK;
                else if (w_timeout) w_next = w_stall_next;
            end
            S_GAP:   w_next = S_RD_ID;
            S_CHECK: w_next = S_DONE;
            S_DONE,
            S_FAIL:  if (start) w_next = S_RD_ID;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_launch = ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL))
                      && (w_next == S_RD_ID);

    // Bus strobes and status are registered from the next state so they never glitch.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 16'd0;
            r_avm_read    <= 1'b0;
            r_avm_address <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_captured_id <= 32'd0;
            r_captured_ts <= 32'd0;
            r_retries     <= 4'd0;
        end else begin
            r_state       <= w_next;
            r_avm_read    <= (w_next == S_RD_ID) || (w_next == S_RD_TS);
            r_avm_address <= (w_next == S_RD_TS);
            r_busy        <= (w_next == S_RD_ID) || (w_next == S_RD_TS)
                             || (w_next == S_GAP) || (w_next == S_CHECK);
            r_done        <= (w_next == S_DONE) || (w_next == S_FAIL);
            r_timeout_err <= (w_next == S_FAIL);

            if (w_reading && avm_waitrequest && (w_next == r_state))
                r_cnt <= w_cnt_inc;
            else
                r_cnt <= 16'd0;

            if ((r_state == S_RD_ID) && w_accept) r_captured_id <= avm_readdata;
            if ((r_state == S_RD_TS) && w_accept) r_captured_ts <= avm_readdata;

            if (w_launch)
                r_retries <= 4'd0;
            else if (w_next == S_GAP)
                r_retries <= r_retries + 4'd1;

            if (w_launch || (w_next == S_FAIL)) begin
                r_pass  <= 1'b0;
                r_id_ok <= 1'b0;
                r_ts_ok <= 1'b0;
            end else if (r_state == S_CHECK) begin
                r_id_ok <= (r_captured_id == EXPECTED_ID);
                r_ts_ok <= (r_captured_ts == EXPECTED_TS);
                r_pass  <= (r_captured_id == EXPECTED_ID) && (r_captured_ts == EXPECTED_TS);
            end
        end
    end

    assign avm_read     = r_avm_read;
    assign avm_address  = r_avm_address;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign id_ok        = r_id_ok;
    assign ts_ok        = r_ts_ok;
    assign timeout_err  = r_timeout_err;
    assign captured_id  = r_captured_id;
    assign captured_ts  = r_captured_ts;
    assign retries_used = r_retries;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: a scripted-stall Avalon slave plus a per-run outcome model
// (attempts, retries, latency, read-cycle count, flags) computed from the sequencing rules.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1498439491;
    localparam int          TO     = 4;
    localparam int          MR     = 2;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout_err;
    logic [31:0] captured_id;
    logic [31:0] captured_ts;
    logic [3:0]  retries_used;

    int          n_checks;
    int          n_errors;

    int          stall_q[$];
    logic [31:0] sl_id;
    logic [31:0] sl_ts;
    bit          sl_active;
    int          sl_left;

    logic [31:0] m_cap_id;
    logic [31:0] m_cap_ts;

    sysid_boot_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRIES    (MR),
        .AUTO_START     (1'b1)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout_err     (timeout_err),
        .captured_id     (captured_id),
        .captured_ts     (captured_ts),
        .retries_used    (retries_used)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each read request (new strobe or new address after an accept) stalls for the next scripted count.
    initial begin
        sl_active       = 1'b0;
        sl_left         = 0;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'd0;
        forever begin
            @(negedge clock);
            if (sl_active) begin
                if (!avm_waitrequest) sl_active = 1'b0;
                else if (sl_left > 0) sl_left--;
            end
            if (!avm_read) sl_active = 1'b0;
            if (avm_read && !sl_active) begin
                sl_active = 1'b1;
                if (stall_q.size() > 0) sl_left = stall_q.pop_front();
                else                    sl_left = 0;
            end
            avm_waitrequest = sl_active && (sl_left > 0);
            avm_readdata    = avm_address ? sl_ts : sl_id;
        end
    end

    function automatic int pick_stall(input int mode, input int ph);
        case (mode)
            0:       return int'($urandom_range(0, 5));
            1:       return 0;
            2:       return 10;
            default: return (ph == 0) ? TO : 0;
        endcase
    endfunction

    task automatic run_check(input bit via_reset, input bit poke, input int mode,
                             input logic [31:0] idv, input logic [31:0] tsv);
        int retries, cyc, reads, ph, s, n, obs_reads;
        bit fin, fail, to, got;
        retries = 0; cyc = 0; reads = 0; ph = 0; fin = 1'b0; fail = 1'b0;
        // Outcome model: each attempt reads word 0 then word 1; a stall of TO or more aborts it.
        while (!fin) begin
            to = 1'b0;
            for (int w = 0; w < 2; w++) begin
                if (!to) begin
                    s = pick_stall(mode, ph);
                    ph++;
                    stall_q.push_back(s);
                    if (s >= TO) begin
                        to = 1'b1;
                        cyc += TO;
                        reads += TO;
                    end else begin
                        cyc += s + 1;
                        reads += s + 1;
                        if (w == 0) m_cap_id = idv;
                        else        m_cap_ts = tsv;
                    end
                end
            end
            if (!to) begin
                cyc += 1;
                fin = 1'b1;
            end else if (retries < MR) begin
                retries++;
                cyc += 1;
            end else begin
                fail = 1'b1;
                fin = 1'b1;
            end
        end
        sl_id = idv;
        sl_ts = tsv;

        @(negedge clock);
        if (via_reset) reset_n = 1'b1;
        else           start = 1'b1;
        @(posedge clock);
        n = 0; obs_reads = 0; got = 1'b0;
        while ((n < 300) && !got) begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                start = 1'b0;
                chk("first_read", 80'({avm_read, avm_address}), 80'(2'b10));
                chk("done_clear", 80'(done), 80'(1'b0));
            end
            if (poke && (n == 2)) start = 1'b1;
            if (poke && (n == 3)) start = 1'b0;
            if (avm_read) obs_reads++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk("latency", 80'(n), 80'(cyc + 1));
        repeat (3) begin
            @(negedge clock);
            if (avm_read) obs_reads++;
        end
        chk("read_cycles", 80'(obs_reads), 80'(reads));
        chk("done",        80'(done), 80'(1'b1));
        chk("busy",        80'(busy), 80'(1'b0));
        chk("pass",        80'(pass), 80'(!fail && (idv == EXP_ID) && (tsv == EXP_TS)));
        chk("id_ok",       80'(id_ok), 80'(!fail && (idv == EXP_ID)));
        chk("ts_ok",       80'(ts_ok), 80'(!fail && (tsv == EXP_TS)));
        chk("timeout_err", 80'(timeout_err), 80'(fail));
        chk("retries",     80'(retries_used), 80'(retries));
        chk("cap_id",      80'(captured_id), 80'(m_cap_id));
        chk("cap_ts",      80'(captured_ts), 80'(m_cap_ts));
    endtask

    initial begin
        logic [31:0] idv, tsv;
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        sl_id    = 32'd0;
        sl_ts    = 32'd0;
        m_cap_id = 32'd0;
        m_cap_ts = 32'd0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_state", 80'({avm_read, avm_address, busy, done, pass, id_ok, ts_ok,
                                timeout_err, retries_used, captured_id, captured_ts}), 80'd0);

        run_check(1'b1, 1'b0, 1, EXP_ID, EXP_TS);
        run_check(1'b0, 1'b0, 1, EXP_ID, EXP_TS - 32'd1);
        run_check(1'b0, 1'b0, 2, EXP_ID, EXP_TS);
        run_check(1'b0, 1'b0, 3, EXP_ID, EXP_TS);
        run_check(1'b0, 1'b1, 1, EXP_ID, EXP_TS);

        // Reset while word 1 is stalled must abort everything.
        stall_q.delete();
        stall_q.push_back(0);
        stall_q.push_back(10);
        sl_id = EXP_ID;
        sl_ts = EXP_TS;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("pre_reset_rd_ts", 80'({avm_read, avm_address}), 80'(2'b11));
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("mid_reset", 80'({avm_read, avm_address, busy, done, pass, id_ok, ts_ok,
                              timeout_err, retries_used, captured_id, captured_ts}), 80'd0);
        stall_q.delete();
        m_cap_id = 32'd0;
        m_cap_ts = 32'd0;
        repeat (2) @(negedge clock);
        run_check(1'b1, 1'b0, 1, EXP_ID, EXP_TS);

        for (int i = 0; i < 25; i++) begin
            idv = ($urandom_range(0, 1) != 0) ? EXP_ID : $urandom();
            case ($urandom_range(0, 2))
                0:       tsv = EXP_TS;
                1:       tsv = EXP_TS ^ (32'd1 << $urandom_range(0, 31));
                default: tsv = $urandom();
            endcase
            run_check(1'b0, $urandom_range(0, 1) != 0, 0, idv, tsv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
